// File: rtl/axi4l2mem.sv
// AXI4-Lite slave that terminates reads and writes onto a single-port synchronous SRAM, one transaction at a time.
// Optional macro AXI4L2MEM_DECERR_EN: out-of-range addresses skip the SRAM and answer DECERR.
module axi4l2mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 4096,
    localparam int MEM_AW    = $clog2(MEM_WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic [2:0]            i_awprot,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wstrb,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    output logic [1:0]            o_bresp,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic [2:0]            i_arprot,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic [31:0]           o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [3:0]            o_mem_be,
    output logic [MEM_AW-1:0]     o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic [31:0]           i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WACC,
        S_WRESP,
        S_RACC,
        S_RCAP,
        S_RRESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last_wr;
    logic [MEM_AW-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_err;
    logic [31:0]         r_rdata;

    logic w_wr_cand;
    logic w_rd_cand;
    logic w_wr_win;
    logic w_rd_win;
    logic w_idle;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_aw_err;
    logic w_ar_err;
    logic w_unused;

    // A write needs both AW and W present; on a tie the side not served last goes first.
    assign w_wr_cand = i_awvalid & i_wvalid;
    assign w_rd_cand = i_arvalid;
    assign w_wr_win  = w_wr_cand & ~(w_rd_cand & r_last_wr);
    assign w_rd_win  = w_rd_cand & ~w_wr_win;
    assign w_idle    = (r_state == S_IDLE) & i_rst_n;
    assign w_wr_acc  = w_idle & w_wr_win;
    assign w_rd_acc  = w_idle & w_rd_win;

`ifdef AXI4L2MEM_DECERR_EN
    assign w_aw_err = |i_awaddr[ADDR_WIDTH-1:MEM_AW+2];
    assign w_ar_err = |i_araddr[ADDR_WIDTH-1:MEM_AW+2];
    assign w_unused = ^{i_awprot, i_arprot, i_awaddr[1:0], i_araddr[1:0]};
`else
    assign w_aw_err = 1'b0;
    assign w_ar_err = 1'b0;
    assign w_unused = ^{i_awprot, i_arprot, i_awaddr[1:0], i_araddr[1:0],
                        i_awaddr[ADDR_WIDTH-1:MEM_AW+2], i_araddr[ADDR_WIDTH-1:MEM_AW+2]};
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        o_awready = 1'b0;
        o_wready  = 1'b0;
        o_arready = 1'b0;
        o_mem_req = 1'b0;
        o_mem_we  = 1'b0;
        o_bvalid  = 1'b0;
        o_rvalid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_awready = w_wr_acc;
                o_wready  = w_wr_acc;
                o_arready = w_rd_acc;
                if (w_wr_acc) begin
                    w_next = S_WACC;
                end else if (w_rd_acc) begin
                    w_next = S_RACC;
                end
            end
            S_WACC: begin
                o_mem_req = ~r_err;
                o_mem_we  = 1'b1;
                w_next    = S_WRESP;
            end
            S_WRESP: begin
                o_bvalid = 1'b1;
                if (i_bready) begin
                    w_next = S_IDLE;
                end
            end
            S_RACC: begin
                o_mem_req = ~r_err;
                w_next    = S_RCAP;
            end
            S_RCAP: begin
                w_next = S_RRESP;
            end
            S_RRESP: begin
                o_rvalid = 1'b1;
                if (i_rready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // SRAM read data is only valid for the one cycle after the access, so it is captured in RCAP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_wr <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_wr_acc) begin
                r_addr    <= i_awaddr[MEM_AW+1:2];
                r_wdata   <= i_wdata;
                r_wstrb   <= i_wstrb;
                r_err     <= w_aw_err;
                r_last_wr <= 1'b1;
            end else if (w_rd_acc) begin
                r_addr    <= i_araddr[MEM_AW+1:2];
                r_err     <= w_ar_err;
                r_last_wr <= 1'b0;
            end
            if (r_state == S_RCAP) begin
                r_rdata <= r_err ? 32'h0 : i_mem_rdata;
            end
        end
    end

    assign o_bresp     = {2{r_err}};
    assign o_rresp     = {2{r_err}};
    assign o_rdata     = r_rdata;
    assign o_mem_be    = r_wstrb;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

endmodule

// File: doc/axi4l2mem.md
Name: axi4l2mem

Overview:
- AXI4-Lite slave that sits directly downstream of the core-to-AXI4-Lite bridge and terminates its bus onto a single-port synchronous SRAM.
- Serves one transaction at a time; a read and a write never overlap.
- Arbitrates fairly between simultaneous read and write requests.
- Returns OKAY responses, or DECERR for out-of-range addresses when the optional feature is compiled in.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- MEM_WORDS, 4096, SRAM depth in 32-bit words; power of two. Derived: MEM_AW = $clog2(MEM_WORDS).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- awvalid/awready  in/out  1/1  write address handshake
- awaddr  in  ADDR_WIDTH  write byte address
- awprot  in  3  ignored
- wvalid/wready  in/out  1/1  write data handshake
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- bvalid/bready  out/in  1/1  write response handshake
- bresp  out  2  write response
- arvalid/arready  in/out  1/1  read address handshake
- araddr  in  ADDR_WIDTH  read byte address
- arprot  in  3  ignored
- rvalid/rready  out/in  1/1  read response handshake
- rdata  out  32  read data
- rresp  out  2  read response
- mem_req  out  1  SRAM access strobe, one cycle per access
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables (= wstrb)
- mem_addr  out  MEM_AW  word address = addr[MEM_AW+1:2]
- mem_wdata  out  32  write data
- mem_rdata  in  32  valid exactly one cycle after a read mem_req, not held

Behaviour:
- Reset (async, rst_n=0): state IDLE, last_wr=0.
  - All valid/ready/mem_req outputs 0; mem_we=0.
  - bresp/rresp=2'b00; rdata=0; address/data registers 0.
  - Reset mid-transaction drops it silently; no response is ever issued for it.
- FSM states: IDLE, WACC, WRESP, RACC, RCAP, RRESP.
- Request candidates in IDLE:
  - wr_cand = awvalid && wvalid. AW without W, or W without AW, is not accepted.
  - rd_cand = arvalid.
- Arbitration in IDLE:
  - Only one candidate: it wins.
  - Both candidates: write wins if last_wr=0, else read wins.
  - last_wr is updated on each acceptance (1 = write accepted).
- Ready outputs:
  - awready = wready = (state==IDLE && write wins), combinational.
  - arready = (state==IDLE && read wins).
  - Outside IDLE all readies are 0.
- Write path (accept edge = T):
  - At T, register word address, wdata, wstrb, and the error flag. Go to WACC.
  - WACC (T+1): mem_req=1, mem_we=1, mem_be/mem_addr/mem_wdata from registers. Go to WRESP.
  - WRESP (T+2 onward): bvalid=1, bresp held stable. Return to IDLE on bvalid&&bready.
- Read path (accept edge = T):
  - At T, register word address and error flag. Go to RACC.
  - RACC (T+1): mem_req=1, mem_we=0. Go to RCAP.
  - RCAP (T+2): rdata <= mem_rdata. Go to RRESP.
  - RRESP (T+3 onward): rvalid=1, rdata/rresp stable. Return to IDLE on rvalid&&rready.
- Latency: write accept to bvalid = 2 cycles; read accept to rvalid = 3 cycles.
- Back-to-back: earliest next acceptance is the cycle after the response handshake, since IDLE is re-entered then. Worst-case throughput: write 3 cycles, read 4 cycles.
- awaddr/araddr bits [1:0] are ignored (word-aligned access). Partial wstrb writes only the strobed bytes via mem_be. wstrb=0 still issues mem_req with mem_be=0.
- mem_we, mem_be, mem_addr, mem_wdata are don't-care when mem_req=0, but are driven from registers (no X).

Optional Feature:
- Macro AXI4L2MEM_DECERR_EN.
- Defined:
  - An address with any of bits [ADDR_WIDTH-1:MEM_AW+2] set is out of range.
  - The FSM still passes through WACC/RACC, with mem_req=0 there, so latency is identical.
  - Response is bresp/rresp=2'b11 (DECERR); rdata=0 for errored reads.
- Undefined:
  - Upper address bits are ignored; addresses alias modulo MEM_WORDS*4.
  - Responses are always 2'b00.

Test Plan:
- Write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, bready=1 -> at T+1 mem_req=1, mem_we=1, mem_addr=4, mem_be=F; bvalid at T+2 with bresp=00. Then read araddr=0x10 -> mem_req at T+1; rvalid at T+3 with rdata=0xDEADBEEF, rresp=00.
- Partial write wstrb=4'b0010, wdata=0x0000AB00 over 0x11223344 -> mem_be=0010; subsequent read returns 0x1122AB44.
- Reset, then hold awvalid, wvalid, arvalid high continuously with bready=rready=1 -> accepted order is W, R, W, R; readies are never asserted while the FSM is outside IDLE.
- Backpressure: bready=0 for 5 cycles, and separately rready=0 for 5 cycles -> bvalid/bresp and rvalid/rdata/rresp held stable; no ready asserted until the handshake completes.
- AW valid with wvalid=0 for 3 cycles, then wvalid=1 -> awready=0 until wvalid=1; single accept in that cycle.
- araddr=0x0001_0000 with MEM_WORDS=4096 -> with AXI4L2MEM_DECERR_EN: no mem_req, rresp=11, rdata=0 at T+3. Without it: mem_addr=0, rresp=00.
